// File: rtl/sb_timeout_arbiter.sv
// Round-robin owner of the single sideband time-out counter: arms/runs it for one
// requester at a time and returns that requester's expiry as a one-cycle pulse.
module sb_timeout_arbiter #(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned DRAIN_MAX = 15
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [NUM_REQ-1:0] i_done,
   input  logic               i_time_out,
   output logic               o_start_cnt,
   output logic               o_stop_cnt,
   output logic [NUM_REQ-1:0] o_gnt,
   output logic [NUM_REQ-1:0] o_req_time_out,
   output logic               o_busy,
   output logic               o_err
);

   localparam int unsigned PW = $clog2(NUM_REQ);
   localparam int unsigned DW = $clog2(DRAIN_MAX + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARM,
      ST_RUN,
      ST_DRAIN
   } state_e;

   state_e             state_q, state_d;
   logic [PW-1:0]      ptr_q, ptr_d;
   logic [PW-1:0]      gidx_q, gidx_d;
   logic [DW-1:0]      drain_q, drain_d;
   logic               start_q, start_d;
   logic               stop_q, stop_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [NUM_REQ-1:0] rto_q, rto_d;
   logic               busy_q, busy_d;
   logic               err_q, err_d;

   logic               pick_vld;
   logic [PW-1:0]      pick_idx;
   logic [PW:0]        cand;
   logic [PW-1:0]      ptr_nxt;

   // Scan from the pointer upwards with wrap; first active request wins.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      cand     = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand = {1'b0, ptr_q} + (PW+1)'(i);
         if (cand >= (PW+1)'(NUM_REQ)) begin
            cand = cand - (PW+1)'(NUM_REQ);
         end
         if (!pick_vld && i_req[cand[PW-1:0]]) begin
            pick_vld = 1'b1;
            pick_idx = cand[PW-1:0];
         end
      end
   end

   assign ptr_nxt = (gidx_q == PW'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gidx_d  = gidx_q;
      drain_d = drain_q;
      start_d = start_q;
      stop_d  = 1'b0;
      gnt_d   = gnt_q;
      rto_d   = '0;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_vld) begin
               gidx_d  = pick_idx;
               gnt_d   = NUM_REQ'(1) << pick_idx;
               stop_d  = 1'b1;
               state_d = ST_ARM;
            end
         end
         ST_ARM: begin
            start_d = 1'b1;
            state_d = ST_RUN;
         end
         ST_RUN: begin
            // Completion outranks a coincident expiry.
            if (i_done[gidx_q] || !i_req[gidx_q]) begin
               start_d = 1'b0;
               stop_d  = 1'b1;
               gnt_d   = '0;
               ptr_d   = ptr_nxt;
               state_d = ST_IDLE;
            end else if (i_time_out) begin
               start_d = 1'b0;
               rto_d   = gnt_q;
               drain_d = '0;
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (!i_time_out) begin
               gnt_d   = '0;
               ptr_d   = ptr_nxt;
               drain_d = '0;
               state_d = ST_IDLE;
            end else if (drain_q == DW'(DRAIN_MAX - 1)) begin
               err_d   = 1'b1;
               gnt_d   = '0;
               ptr_d   = ptr_nxt;
               drain_d = '0;
               state_d = ST_IDLE;
            end else begin
               drain_d = drain_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         gidx_q  <= '0;
         drain_q <= '0;
         start_q <= 1'b0;
         stop_q  <= 1'b0;
         gnt_q   <= '0;
         rto_q   <= '0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gidx_q  <= gidx_d;
         drain_q <= drain_d;
         start_q <= start_d;
         stop_q  <= stop_d;
         gnt_q   <= gnt_d;
         rto_q   <= rto_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
      end
   end

   assign o_start_cnt    = start_q;
   assign o_stop_cnt     = stop_q;
   assign o_gnt          = gnt_q;
   assign o_req_time_out = rto_q;
   assign o_busy         = busy_q;
   assign o_err          = err_q;

endmodule

// File: tb/tb_sb_timeout_arbiter.sv
// Bench for sb_timeout_arbiter: directed scenarios plus random traffic against an
// owner/age reference model and a behavioural time-out counter.
module tb_sb_timeout_arbiter;

   localparam int N    = 4;
   localparam int DMAX = 15;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [N-1:0] req;
   logic [N-1:0] done;
   logic         to;
   logic         start;
   logic         stop;
   logic [N-1:0] gnt;
   logic [N-1:0] rto;
   logic         busy;
   logic         err;

   always #5 clk = ~clk;

   sb_timeout_arbiter #(
      .NUM_REQ  (N),
      .DRAIN_MAX(DMAX)
   ) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_req         (req),
      .i_done        (done),
      .i_time_out    (to),
      .o_start_cnt   (start),
      .o_stop_cnt    (stop),
      .o_gnt         (gnt),
      .o_req_time_out(rto),
      .o_busy        (busy),
      .o_err         (err)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference: who owns the counter, whether it is armed yet, whether it expired.
   int           m_owner;
   int           m_ptr;
   int           m_drain;
   bit           m_armed;
   bit           m_expired;
   bit           m_err;
   logic [N-1:0] e_gnt;
   logic [N-1:0] e_rto;
   logic         e_start;
   logic         e_stop;

   int           c_cnt;
   int           window;
   bit           force_to;
   logic [N-1:0] prev_gnt;
   int           grant_log[$];

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic bit bit_of(input logic [N-1:0] v, input int k);
      logic [N-1:0] sh;
      sh = v >> k;
      return sh[0];
   endfunction

   function automatic int rr_pick(input logic [N-1:0] r, input int p);
      for (int i = 0; i < N; i++) begin
         if (bit_of(r, (p + i) % N)) return (p + i) % N;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_owner = -1; m_ptr = 0; m_drain = 0;
      m_armed = 0; m_expired = 0; m_err = 0;
      e_gnt = '0; e_rto = '0; e_start = 0; e_stop = 0;
   endtask

   task automatic release_owner();
      m_ptr     = (m_owner + 1) % N;
      m_owner   = -1;
      m_expired = 0;
   endtask

   task automatic model_step();
      bit fire;
      int k;
      fire   = 0;
      e_stop = 0;
      if (m_owner < 0) begin
         k = rr_pick(req, m_ptr);
         if (k >= 0) begin
            m_owner = k; m_armed = 0; m_expired = 0; e_stop = 1;
         end
      end else if (!m_armed) begin
         m_armed = 1;
      end else if (!m_expired) begin
         if (bit_of(done, m_owner) || !bit_of(req, m_owner)) begin
            e_stop = 1;
            release_owner();
         end else if (to) begin
            m_expired = 1; m_drain = 0; fire = 1;
         end
      end else begin
         if (!to) release_owner();
         else begin
            m_drain++;
            if (m_drain == DMAX) begin
               m_err = 1;
               release_owner();
            end
         end
      end
      e_gnt   = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
      e_rto   = fire ? e_gnt : '0;
      e_start = (m_owner >= 0) && m_armed && !m_expired;
   endtask

   // Counter: counts while start is high, raises time_out at the window, drops it once start is low.
   task automatic counter_step();
      if (!rst_n) begin
         c_cnt = 0; to = 1'b0;
      end else if (stop) begin
         c_cnt = 0; to = force_to;
      end else if (start) begin
         c_cnt++;
         if (c_cnt >= window) to = 1'b1;
      end else begin
         c_cnt = 0; to = force_to;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_step();
      @(negedge clk);
      check("gnt",   gnt,   e_gnt);
      check("start", start, e_start);
      check("stop",  stop,  e_stop);
      check("rto",   rto,   e_rto);
      check("busy",  busy,  m_owner >= 0);
      check("err",   err,   m_err);
      if (gnt != '0 && prev_gnt == '0) begin
         for (int k = 0; k < N; k++) if (bit_of(gnt, k)) grant_log.push_back(k);
      end
      prev_gnt = gnt;
      counter_step();
   endtask

   task automatic do_reset();
      rst_n = 1'b0; req = '0; done = '0; force_to = 0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 60 && busy; i++) tick();
      check(tag, busy, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int lat;
      int n;
      int exp3[5];
      exp3 = '{0, 1, 2, 3, 0};
      rst_n = 1'b0; req = '0; done = '0; to = 1'b0; force_to = 0;
      window = 800; c_cnt = 0; prev_gnt = '0;
      model_reset();
      tick();
      tick();
      check("rst_gnt",   gnt,   '0);
      check("rst_start", start, 1'b0);
      check("rst_stop",  stop,  1'b0);
      check("rst_busy",  busy,  1'b0);
      check("rst_err",   err,   1'b0);
      rst_n = 1'b1;

      // Lone requester runs to expiry.
      req = 4'b0010;
      lat = 1; tick();
      check("t1_gnt", gnt, 4'b0010);
      check("t1_stop", stop, 1'b1);
      lat = 2; tick();
      check("t1_start", start, 1'b1);
      while (rto == '0 && lat < 1000) begin
         tick(); lat++;
      end
      check("t1_lat", lat, 802);
      check("t1_rto", rto, 4'b0010);
      check("t1_start_drop", start, 1'b0);
      req = '0;
      tick();
      check("t1_gnt_clr", gnt, '0);
      check("t1_idle", busy, 1'b0);
      req = 4'b0101;
      tick();
      check("t1_ptr", gnt, 4'b0100);
      req = '0;
      wait_idle("t1_probe_idle");

      // Early completion.
      req = 4'b0001;
      tick();
      check("t2_gnt", gnt, 4'b0001);
      repeat (48) tick();
      done = 4'b0001;
      tick();
      done = '0;
      check("t2_stop", stop, 1'b1);
      check("t2_start", start, 1'b0);
      check("t2_gnt", gnt, '0);
      check("t2_rto", rto, '0);
      req = '0;
      wait_idle("t2_idle");

      // Round-robin over all requesters from pointer 0.
      do_reset();
      grant_log.delete();
      req = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         for (int i = 0; i < 50 && gnt == '0; i++) tick();
         repeat (10) tick();
         done = gnt;
         tick();
         done = '0;
      end
      req = '0;
      wait_idle("t3_idle");
      check("t3_count", grant_log.size(), 5);
      for (int i = 0; i < grant_log.size() && i < 5; i++) check("t3_order", grant_log[i], exp3[i]);

      // Done coincident with expiry.
      window = 20;
      req = 4'b0100;
      for (int i = 0; i < 200 && !to; i++) tick();
      check("t4_to_seen", to, 1'b1);
      done = 4'b0100;
      tick();
      done = '0;
      check("t4_rto", rto, '0);
      check("t4_stop", stop, 1'b1);
      check("t4_idle", busy, 1'b0);
      req = '0;
      wait_idle("t4_idle2");

      // Time-out stuck high after expiry.
      req = 4'b1000;
      for (int i = 0; i < 200 && !to; i++) tick();
      check("t5_to_seen", to, 1'b1);
      force_to = 1;
      tick();
      check("t5_rto", rto, 4'b1000);
      req = '0;
      n = 0;
      while (busy && n < 40) begin
         tick(); n++;
      end
      check("t5_drain_len", n, DMAX);
      check("t5_err", err, 1'b1);
      force_to = 0;
      repeat (5) tick();
      check("t5_err_sticky", err, 1'b1);

      // Asynchronous reset mid-window.
      req = 4'b0010;
      repeat (5) tick();
      check("t6_running", start, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("t6_start", start, 1'b0);
      check("t6_gnt", gnt, '0);
      check("t6_busy", busy, 1'b0);
      check("t6_err", err, 1'b0);
      tick();
      tick();
      rst_n = 1'b1;
      req = 4'b0101;
      tick();
      check("t6_gnt0", gnt, 4'b0001);
      req = '0;
      wait_idle("t6_idle");

      // Random traffic.
      window = 25;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(5, 0) == 0) req = req ^ (N'(1) << $urandom_range(N - 1, 0));
         done = N'($urandom) & N'($urandom) & N'($urandom);
         if (!force_to && $urandom_range(199, 0) == 0) force_to = 1;
         else if (force_to && $urandom_range(9, 0) == 0) force_to = 0;
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
